vga_fb_scanout: RTL and testbench
=================================

VGA_FB_SCANOUT -- requirements
Module: vga_fb_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, 480, visible lines per frame.
REQ-003 SHALL have parameter H_TOTAL, 800, pixel ticks per line (16 front porch, 96 sync, 48 back porch).
REQ-004 SHALL have parameter V_TOTAL, 525, lines per frame (10 front porch, 2 sync, 33 back porch).
REQ-005 SHALL have port clock, input, 1, 50 MHz system clock.
REQ-006 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port wr_x, input, 10, framebuffer write column.
REQ-008 SHALL have port wr_y, input, 10, framebuffer write row.
REQ-009 SHALL have port wr_color, input, 3, write colour {R,G,B}.
REQ-010 SHALL have port write, input, 1, write strobe, sampled every clock.
REQ-011 SHALL have ports VGA_R, VGA_G and VGA_B, output, 8 each, DAC colour.
REQ-012 SHALL have ports VGA_HS and VGA_VS, output, 1 each, active-low syncs.
REQ-013 SHALL have ports VGA_BLANK_N and VGA_SYNC_N, output, 1 each, DAC blank and sync controls.
REQ-014 SHALL have port VGA_CLK, output, 1, 25 MHz pixel clock.
REQ-015 SHALL have port vblank, output, 1, high while the scan is outside the visible lines.

Function
REQ-016 SHALL hold an internal tick register that toggles every clock; a pixel tick is a clock with tick=1; VGA_CLK = tick.
REQ-017 SHALL have an h counter 0..H_TOTAL-1 advancing on each pixel tick and wrapping to 0; at wrap, v advances 0..V_TOTAL-1 and wraps to 0.
REQ-018 SHALL store a 640x480x3 framebuffer at address wr_y*640+wr_x, zero-initialised at configuration.
REQ-019 SHALL write the framebuffer on any clock where write=1, wr_x<640 and wr_y<480, independent of the pixel tick.
REQ-020 SHALL silently drop writes with wr_x>=640 or wr_y>=480, leaving memory unchanged.
REQ-021 SHALL, on a same-clock write and scan read of the same address, return the old data to the scan; the new value is visible from the next frame.
REQ-022 SHALL pipeline the scan in two pixel-tick stages: stage 1 registers the read address and raw timing flags, stage 2 registers the memory data and timing flags.
REQ-023 SHALL drive outputs from stage 2, so pixel (h,v) appears exactly 2 pixel ticks after the counters hold (h,v).
REQ-024 SHALL delay HS, VS and BLANK by the same 2 ticks as the pixel data, keeping data and sync aligned.
REQ-025 SHALL drive raw HS low for h in 656..751 and raw VS low for v in 490..491.
REQ-026 SHALL set raw active = (h<640)&&(v<480) and VGA_BLANK_N = delayed active.
REQ-027 SHALL force RGB to 0 when delayed active=0; otherwise each colour bit expands to 8'hFF when 1 and 8'h00 when 0.
REQ-028 SHALL hold VGA_SYNC_N constant 0.
REQ-029 SHALL set vblank = (v>=480), registered, updating on the pixel tick on which v changes.
REQ-030 SHALL present the same read address during both clocks of a pixel tick and hold all outputs stable between pixel ticks.

Reset
REQ-031 SHALL, while resetn=0, clear tick, h, v and both pipeline stages and drive RGB=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_CLK=0, vblank=0.
REQ-032 SHALL leave framebuffer contents unchanged on reset and ignore write while resetn=0.
REQ-033 SHALL, on release mid-frame, restart from h=0, v=0 with pixel (0,0) on VGA_R/G/B 2 pixel ticks (4 clocks) after the first tick.

Verification
REQ-034 SHALL pass: reset release with no writes -> HS period 1600 clocks with a 192-clock low pulse; VS period 840000 clocks with a 3200-clock low pulse; RGB always 0.
REQ-035 SHALL pass: write (0,0)=3'b100 and (639,479)=3'b011 -> next frame shows R=FF,G=00,B=00 at the first visible pixel and R=00,G=FF,B=FF at the last; BLANK_N=1 for exactly 640 ticks per visible line.
REQ-036 SHALL pass: write (640,0)=7 and (0,480)=7 -> no visible pixel changes; memory at (0,0) and (639,479) is unchanged.
REQ-037 SHALL pass: write (5,10)=3'b111 on the same clock the scan reads (5,10) -> current frame shows the old colour; the next frame shows white.
REQ-038 SHALL pass: resetn pulsed low at h=300, v=200 -> outputs take reset values immediately; after release, the first HS low occurs 656 ticks after the first tick, plus 2 ticks of latency.
REQ-039 SHALL pass: vblank observed -> rises when v becomes 480 and falls when v wraps to 0, with a high time of 45 lines (72000 clocks).

Source files
------------

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: 3-bit colour framebuffer with a VGA raster scan-out.
// Pixel rate is clock/2; video and syncs lag the raster counters by two pixel ticks.

module vga_fb_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [9:0] wr_x,
    input  logic [9:0] wr_y,
    input  logic [2:0] wr_color,
    input  logic       write,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK,
    output logic       vblank
);

    localparam int NPIX   = H_ACTIVE * V_ACTIVE;
    localparam int AW     = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int HW     = $clog2(H_TOTAL);
    localparam int VW     = $clog2(V_TOTAL);
    localparam int HS_BEG = H_ACTIVE + H_FP;
    localparam int HS_END = HS_BEG + H_SYNC;
    localparam int VS_BEG = V_ACTIVE + V_FP;
    localparam int VS_END = VS_BEG + V_SYNC;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    // Pixel-rate divider and raster position
    logic          tick_q, tick_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          vblank_q, vblank_d;

    // Stage 1: read address and raw timing flags
    logic [AW-1:0] s1_addr_q, s1_addr_d;
    logic          s1_act_q, s1_act_d;
    logic          s1_hs_n_q, s1_hs_n_d;
    logic          s1_vs_n_q, s1_vs_n_d;

    // Stage 2: timing flags (colour lives in the framebuffer read register)
    logic          s2_act_q, s2_act_d;
    logic          s2_hs_n_q, s2_hs_n_d;
    logic          s2_vs_n_q, s2_vs_n_d;

    // Framebuffer storage and its scan read register
    logic [2:0]    fb_mem [NPIX];
    logic [2:0]    rd_q;

    // Raw per-position flags and addresses
    logic          raw_act;
    logic          raw_hs_n;
    logic          raw_vs_n;
    logic [AW-1:0] raw_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    // Addresses are formed modulo 2^AW; valid positions never exceed NPIX-1.
    assign raw_act  = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    assign raw_hs_n = !((int'(h_q) >= HS_BEG) && (int'(h_q) < HS_END));
    assign raw_vs_n = !((int'(v_q) >= VS_BEG) && (int'(v_q) < VS_END));
    assign raw_addr = raw_act
                    ? AW'(v_q) * AW'(H_ACTIVE) + AW'(h_q)
                    : '0;

    assign wr_en   = write && resetn
                   && (int'(wr_x) < H_ACTIVE)
                   && (int'(wr_y) < V_ACTIVE);
    assign wr_addr = AW'(wr_y) * AW'(H_ACTIVE) + AW'(wr_x);

    // Divider toggle and h/v raster counters advancing on pixel ticks
    always_comb begin
        tick_d   = ~tick_q;
        h_d      = h_q;
        v_d      = v_q;
        vblank_d = vblank_q;
        if (tick_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + VW'(1);
                end
            end else begin
                h_d = h_q + HW'(1);
            end
            vblank_d = (int'(v_d) >= V_ACTIVE);
        end
    end

    // Two-stage scan pipeline, both stages advancing on pixel ticks
    always_comb begin
        s1_addr_d = s1_addr_q;
        s1_act_d  = s1_act_q;
        s1_hs_n_d = s1_hs_n_q;
        s1_vs_n_d = s1_vs_n_q;
        s2_act_d  = s2_act_q;
        s2_hs_n_d = s2_hs_n_q;
        s2_vs_n_d = s2_vs_n_q;
        if (tick_q) begin
            s1_addr_d = raw_addr;
            s1_act_d  = raw_act;
            s1_hs_n_d = raw_hs_n;
            s1_vs_n_d = raw_vs_n;
            s2_act_d  = s1_act_q;
            s2_hs_n_d = s1_hs_n_q;
            s2_vs_n_d = s1_vs_n_q;
        end
    end

    // Timing and pipeline registers; syncs idle high in reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tick_q    <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            vblank_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_act_q  <= 1'b0;
            s1_hs_n_q <= 1'b1;
            s1_vs_n_q <= 1'b1;
            s2_act_q  <= 1'b0;
            s2_hs_n_q <= 1'b1;
            s2_vs_n_q <= 1'b1;
        end else begin
            tick_q    <= tick_d;
            h_q       <= h_d;
            v_q       <= v_d;
            vblank_q  <= vblank_d;
            s1_addr_q <= s1_addr_d;
            s1_act_q  <= s1_act_d;
            s1_hs_n_q <= s1_hs_n_d;
            s1_vs_n_q <= s1_vs_n_d;
            s2_act_q  <= s2_act_d;
            s2_hs_n_q <= s2_hs_n_d;
            s2_vs_n_q <= s2_vs_n_d;
        end
    end

    // Framebuffer: free-running write port, tick-enabled read-before-write scan port
    always_ff @(posedge clock) begin
        if (wr_en) begin
            fb_mem[wr_addr] <= wr_color;
        end
        if (tick_q) begin
            rd_q <= fb_mem[s1_addr_q];
        end
    end

    // Colour is gated by the delayed active flag, so a stale read register is never shown.
    assign VGA_R       = (s2_act_q && rd_q[2]) ? 8'hFF : 8'h00;
    assign VGA_G       = (s2_act_q && rd_q[1]) ? 8'hFF : 8'h00;
    assign VGA_B       = (s2_act_q && rd_q[0]) ? 8'hFF : 8'h00;
    assign VGA_HS      = s2_hs_n_q;
    assign VGA_VS      = s2_vs_n_q;
    assign VGA_BLANK_N = s2_act_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = tick_q;
    assign vblank      = vblank_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: randomized scan-out checks against a raster-position model.
// Uses a shrunken raster so whole frames fit in a short run.

module tb_vga_fb_scanout;

    localparam int HA  = 16;
    localparam int VA  = 6;
    localparam int HFP = 4;
    localparam int HSY = 8;
    localparam int HT  = 32;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VT  = 12;
    localparam int FT  = HT * VT;

    logic       clock;
    logic       resetn;
    logic [9:0] wr_x;
    logic [9:0] wr_y;
    logic [2:0] wr_color;
    logic       write;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic       VGA_CLK;
    logic       vblank;

    vga_fb_scanout #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
        .H_FP(HFP), .H_SYNC(HSY), .V_FP(VFP), .V_SYNC(VSY)
    ) dut (
        .clock(clock), .resetn(resetn),
        .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .write(write),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
        .VGA_CLK(VGA_CLK), .vblank(vblank)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int         total = 0;
    int         bad   = 0;
    int         c     = 0;
    logic [2:0] mmem [HA*VA];
    logic [2:0] shown = 3'b000;
    logic [29:0] got;

    assign got = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
                  VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, vblank};

    function automatic logic [23:0] rgb24(input logic [2:0] col);
        return {{8{col[2]}}, {8{col[1]}}, {8{col[0]}}};
    endfunction

    // Expected outputs after clock edge cc since reset release.
    function automatic logic [29:0] exp_out(input int cc);
        int k, p, h, v;
        logic hs, vs, bn, vb, ck;
        logic [2:0] col;
        k   = cc / 2;
        ck  = (cc % 2) == 1;
        vb  = ((k % FT) / HT) >= VA;
        hs  = 1'b1;
        vs  = 1'b1;
        bn  = 1'b0;
        col = 3'b000;
        if (k >= 2) begin
            p  = (k - 2) % FT;
            h  = p % HT;
            v  = p / HT;
            bn = (h < HA) && (v < VA);
            hs = !((h >= HA + HFP) && (h < HA + HFP + HSY));
            vs = !((v >= VA + VFP) && (v < VA + VFP + VSY));
            if (bn) col = shown;
        end
        return {rgb24(col), hs, vs, bn, 1'b0, ck, vb};
    endfunction

    // One clock: model latches the colour read at this pixel tick, then applies the write.
    task automatic step();
        int k, p, h, v;
        @(posedge clock);
        if (!resetn) begin
            c = 0;
        end else begin
            c++;
            if (c % 2 == 0) begin
                k = c / 2;
                if (k >= 2) begin
                    p = (k - 2) % FT;
                    h = p % HT;
                    v = p / HT;
                    if (h < HA && v < VA) shown = mmem[v*HA + h];
                end
            end
            if (write && int'(wr_x) < HA && int'(wr_y) < VA)
                mmem[int'(wr_y)*HA + int'(wr_x)] = wr_color;
        end
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        write  = 1'b0;
        wr_x   = '0;
        wr_y   = '0;
        wr_color = '0;
        c = 0;
        for (int i = 0; i < 6; i++) begin
            write    = 1'b1;
            wr_x     = 10'($urandom_range(0, HA-1));
            wr_y     = 10'($urandom_range(0, VA-1));
            wr_color = 3'($urandom);
            step();
            total++;
            if (got !== exp_out(c)) begin
                bad++;
                $display("FAIL reset_state got=%h want=%h", got, exp_out(c));
            end
        end
        write = 1'b0;
    endtask

    task automatic test_fill();
        resetn = 1'b1;
        for (int a = 0; a < HA*VA; a++) begin
            write    = 1'b1;
            wr_x     = 10'(a % HA);
            wr_y     = 10'(a / HA);
            wr_color = 3'($urandom);
            step();
        end
        write = 1'b0;
    endtask

    task automatic test_scan(input int frames);
        for (int i = 0; i < frames*2*FT; i++) begin
            write    = ($urandom_range(0, 3) == 0);
            wr_x     = 10'($urandom_range(0, HA+1));
            wr_y     = 10'($urandom_range(0, VA));
            wr_color = 3'($urandom);
            step();
            total++;
            if (got !== exp_out(c)) begin
                bad++;
                $display("FAIL scan c=%0d got=%h want=%h", c, got, exp_out(c));
            end
        end
        write = 1'b0;
    endtask

    task automatic test_corners();
        int n;
        int bn_cnt [VT];
        write = 1'b1;
        wr_x = 10'd0; wr_y = 10'd0; wr_color = 3'b100;
        step();
        wr_x = 10'(HA-1); wr_y = 10'(VA-1); wr_color = 3'b011;
        step();
        write = 1'b0;
        n = 0;
        while (!(c % 2 == 0 && ((c/2 - 2) % FT) == 0) && n < 4*FT) begin
            step();
            n++;
        end
        total++;
        if (n >= 4*FT) begin
            bad++;
            $display("FAIL corners_align got=%0d want<%0d", n, 4*FT);
        end
        for (int l = 0; l < VT; l++) bn_cnt[l] = 0;
        for (int t = 0; t < FT; t++) begin
            if (t == 0) begin
                total++;
                if ({VGA_R, VGA_G, VGA_B} !== 24'hFF0000) begin
                    bad++;
                    $display("FAIL corner_first got=%h want=FF0000",
                             {VGA_R, VGA_G, VGA_B});
                end
            end
            if (t == (VA-1)*HT + HA-1) begin
                total++;
                if ({VGA_R, VGA_G, VGA_B} !== 24'h00FFFF) begin
                    bad++;
                    $display("FAIL corner_last got=%h want=00FFFF",
                             {VGA_R, VGA_G, VGA_B});
                end
            end
            if (VGA_BLANK_N === 1'b1) bn_cnt[t/HT]++;
            step();
            step();
        end
        for (int l = 0; l < VT; l++) begin
            total++;
            if (bn_cnt[l] != ((l < VA) ? HA : 0)) begin
                bad++;
                $display("FAIL blank_line l=%0d got=%0d want=%0d",
                         l, bn_cnt[l], (l < VA) ? HA : 0);
            end
        end
    endtask

    task automatic test_oob();
        int n;
        write = 1'b1;
        wr_x = 10'(HA); wr_y = 10'd0; wr_color = 3'b111;
        step();
        wr_x = 10'd0; wr_y = 10'(VA);
        step();
        write = 1'b0;
        n = 0;
        while (!(c % 2 == 0 && ((c/2 - 2) % FT) == 0) && n < 4*FT) begin
            step();
            n++;
        end
        total++;
        if (n >= 4*FT) begin
            bad++;
            $display("FAIL oob_align got=%0d want<%0d", n, 4*FT);
        end
        for (int t = 0; t < FT; t++) begin
            if ((t % HT) < HA && (t / HT) < VA) begin
                total++;
                if ({VGA_R, VGA_G, VGA_B} !== rgb24(mmem[(t/HT)*HA + t%HT])) begin
                    bad++;
                    $display("FAIL oob_pixel t=%0d got=%h want=%h", t,
                             {VGA_R, VGA_G, VGA_B}, rgb24(mmem[(t/HT)*HA + t%HT]));
                end
            end
            if (t == 0 || t == (VA-1)*HT + HA-1) begin
                total++;
                if ({VGA_R, VGA_G, VGA_B} !== ((t == 0) ? 24'hFF0000 : 24'h00FFFF)) begin
                    bad++;
                    $display("FAIL oob_corner t=%0d got=%h", t, {VGA_R, VGA_G, VGA_B});
                end
            end
            step();
            step();
        end
    endtask

    task automatic test_same_clock();
        int n;
        int p;
        p = 2*HT + 5;
        write = 1'b1;
        wr_x = 10'd5; wr_y = 10'd2; wr_color = 3'b001;
        step();
        write = 1'b0;
        repeat (4) step();
        n = 0;
        while (!(((c+1) % 2 == 0) && (((c+1)/2 - 2) % FT) == p) && n < 4*FT) begin
            step();
            n++;
        end
        total++;
        if (n >= 4*FT) begin
            bad++;
            $display("FAIL same_clock_align got=%0d want<%0d", n, 4*FT);
        end
        write = 1'b1;
        wr_x = 10'd5; wr_y = 10'd2; wr_color = 3'b111;
        step();
        write = 1'b0;
        total++;
        if ({VGA_R, VGA_G, VGA_B} !== 24'h0000FF) begin
            bad++;
            $display("FAIL same_clock_old got=%h want=0000FF", {VGA_R, VGA_G, VGA_B});
        end
        repeat (2*FT) step();
        total++;
        if ({VGA_R, VGA_G, VGA_B} !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL same_clock_new got=%h want=FFFFFF", {VGA_R, VGA_G, VGA_B});
        end
    endtask

    task automatic test_sync_timing();
        int hf = -1, hper = -1, hlow = -1;
        int vf = -1, vper = -1, vlow = -1;
        int br = -1, bper = -1, bhigh = -1, bpos = -1;
        logic ph, pv, pb;
        ph = VGA_HS;
        pv = VGA_VS;
        pb = vblank;
        for (int i = 0; i < 3*2*FT; i++) begin
            step();
            if (ph && !VGA_HS) begin
                if (hf >= 0 && hper < 0) hper = c - hf;
                hf = c;
            end
            if (!ph && VGA_HS && hf >= 0 && hlow < 0) hlow = c - hf;
            if (pv && !VGA_VS) begin
                if (vf >= 0 && vper < 0) vper = c - vf;
                vf = c;
            end
            if (!pv && VGA_VS && vf >= 0 && vlow < 0) vlow = c - vf;
            if (!pb && vblank) begin
                if (br >= 0 && bper < 0) bper = c - br;
                if (bpos < 0) bpos = (c/2) % FT;
                br = c;
            end
            if (pb && !vblank && br >= 0 && bhigh < 0) bhigh = c - br;
            ph = VGA_HS;
            pv = VGA_VS;
            pb = vblank;
        end
        total += 7;
        if (hper != 2*HT) begin
            bad++; $display("FAIL hs_period got=%0d want=%0d", hper, 2*HT);
        end
        if (hlow != 2*HSY) begin
            bad++; $display("FAIL hs_low got=%0d want=%0d", hlow, 2*HSY);
        end
        if (vper != 2*FT) begin
            bad++; $display("FAIL vs_period got=%0d want=%0d", vper, 2*FT);
        end
        if (vlow != 2*VSY*HT) begin
            bad++; $display("FAIL vs_low got=%0d want=%0d", vlow, 2*VSY*HT);
        end
        if (bper != 2*FT) begin
            bad++; $display("FAIL vblank_period got=%0d want=%0d", bper, 2*FT);
        end
        if (bhigh != 2*(VT-VA)*HT) begin
            bad++; $display("FAIL vblank_high got=%0d want=%0d", bhigh, 2*(VT-VA)*HT);
        end
        if (bpos != VA*HT) begin
            bad++; $display("FAIL vblank_rise_pos got=%0d want=%0d", bpos, VA*HT);
        end
    endtask

    task automatic test_midreset();
        int n;
        int hsd;
        n = 0;
        while (!(c % 2 == 0 && ((c/2) % FT) == 3*HT + 10) && n < 4*FT) begin
            step();
            n++;
        end
        total++;
        if (n >= 4*FT) begin
            bad++;
            $display("FAIL midreset_align got=%0d want<%0d", n, 4*FT);
        end
        #2;
        resetn = 1'b0;
        c = 0;
        #1;
        total++;
        if (got !== exp_out(0)) begin
            bad++;
            $display("FAIL midreset_immediate got=%h want=%h", got, exp_out(0));
        end
        write = 1'b1;
        wr_x = 10'd0; wr_y = 10'd0; wr_color = 3'b010;
        repeat (3) step();
        write  = 1'b0;
        resetn = 1'b1;
        hsd = -1;
        for (int i = 0; i < 8*HT && hsd < 0; i++) begin
            step();
            if (c == 3) begin
                total++;
                if (VGA_BLANK_N !== 1'b0) begin
                    bad++;
                    $display("FAIL first_pixel_early got=%b want=0", VGA_BLANK_N);
                end
            end
            if (c == 4) begin
                total++;
                if ({VGA_BLANK_N, VGA_R, VGA_G, VGA_B} !== 25'h1FF0000) begin
                    bad++;
                    $display("FAIL first_pixel got=%h want=1FF0000",
                             {VGA_BLANK_N, VGA_R, VGA_G, VGA_B});
                end
            end
            if (VGA_HS === 1'b0) hsd = c;
        end
        total++;
        if (hsd != 2*(HA + HFP + 2)) begin
            bad++;
            $display("FAIL first_hs_low got=%0d want=%0d", hsd, 2*(HA + HFP + 2));
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_scan(2);
        test_corners();
        test_oob();
        test_same_clock();
        test_sync_timing();
        test_midreset();
        test_scan(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
